// File: rtl/polar_encoder.sv
// Serial polar encoder: loads K info bits around a frozen mask, applies the
// butterfly x = u * F^{(x)n} one stage per cycle, then streams bits and BPSK symbols.
module polar_encoder #(
  parameter int          N      = 8,
  parameter int          LOG2N  = 3,
  parameter int          K      = 4,
  parameter logic [N-1:0] FROZEN = 8'h17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_bit,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_bit,
  output logic [19:0] out_sym,
  output logic        out_last,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and outputs hold while valid && !ready.

  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0]    LAST_INFO  = CW'(K - 1);
  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);
  localparam logic [LOG2N-1:0] LAST_IDX   = LOG2N'(N - 1);
  localparam logic [19:0]      SYM_PLUS   = 20'h01000;
  localparam logic [19:0]      SYM_MINUS  = 20'h81000;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    ENCODE = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     u, u_stage;
  logic [CW-1:0]    info_cnt;
  logic [LOG2N-1:0] p, s, j;
  logic [LOG2N-1:0] idx, stride;
  int               info_seen;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Write position: the info_cnt-th non-frozen index, counting from the bottom.
  always_comb begin
    p         = '0;
    info_seen = 0;
    for (int i = 0; i < N; i++) begin
      if (!FROZEN[i]) begin
        if (info_seen == int'(info_cnt)) p = LOG2N'(i);
        info_seen = info_seen + 1;
      end
    end
  end

  // One butterfly stage: every index with bit s clear folds in its partner.
  always_comb begin
    u_stage = u;
    idx     = '0;
    stride  = LOG2N'(1) << s;
    for (int i = 0; i < N; i++) begin
      idx = LOG2N'(i);
      if ((idx & stride) == '0) u_stage[i] = u[i] ^ u[idx | stride];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_fire && info_cnt == LAST_INFO) state_nxt = ENCODE;
      ENCODE:  if (s == LAST_STAGE)                  state_nxt = OUTPUT;
      OUTPUT:  if (out_fire && j == LAST_IDX)        state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == OUTPUT);
    out_bit   = out_valid ? u[j] : 1'b0;
    out_sym   = out_valid ? (u[j] ? SYM_MINUS : SYM_PLUS) : 20'h00000;
    out_last  = out_valid && (j == LAST_IDX);
    dbg_state = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u        <= '0;
      info_cnt <= '0;
      s        <= '0;
      j        <= '0;
    end else begin
      case (state)
        LOAD: begin
          s <= '0;
          if (in_fire) begin
            u[p]     <= in_bit;
            info_cnt <= (info_cnt == LAST_INFO) ? '0 : info_cnt + CW'(1);
          end
        end
        ENCODE: begin
          u <= u_stage;
          s <= (s == LAST_STAGE) ? '0 : s + LOG2N'(1);
          j <= '0;
        end
        OUTPUT: begin
          if (out_fire) begin
            if (j == LAST_IDX) begin
              j <= '0;
              u <= '0;
            end else begin
              j <= j + LOG2N'(1);
            end
          end
        end
        default: begin
          u        <= '0;
          info_cnt <= '0;
          s        <= '0;
          j        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_polar_encoder.sv
// Bench for polar_encoder: cycle model of the LOAD/ENCODE/OUTPUT timing plus a
// superset-XOR reference for the codeword, directed cases then random traffic.
module tb_polar_encoder;

  localparam int          N      = 8;
  localparam int          LOG2N  = 3;
  localparam int          K      = 4;
  localparam logic [N-1:0] FROZEN = 8'h17;
  localparam logic [19:0] SYM_P  = 20'h01000;
  localparam logic [19:0] SYM_M  = 20'h81000;
  localparam int M_LOAD = 0;
  localparam int M_ENC  = 1;
  localparam int M_OUT  = 2;

  logic        clk, rst;
  logic        in_valid, in_ready, in_bit;
  logic        out_valid, out_ready, out_bit, out_last;
  logic [19:0] out_sym;
  logic [1:0]  dbg_state;

  polar_encoder #(.N(N), .LOG2N(LOG2N), .K(K), .FROZEN(FROZEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_sym(out_sym), .out_last(out_last), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // scoreboard state
  int checks = 0;
  int failures = 0;
  logic [0:0]   exp_q[$];
  logic         info_q[$];
  logic [N-1:0] done_q[$];
  int           info_idx[K];
  int           phase, enc_wait, pos, acc_cnt;
  logic [N-1:0] u_model, rx_word;
  int           in_pct, rdy_pct, pat_idx;
  bit           use_pattern;
  logic [3:0]   rdy_pat;
  logic         stalled, held_bit, held_last;
  logic [19:0]  held_sym;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // x_j = XOR of u_i over all i whose set bits include those of j
  function automatic void push_codeword(input logic [N-1:0] uu);
    for (int jj = 0; jj < N; jj++) begin
      logic x;
      x = 1'b0;
      for (int i = 0; i < N; i++)
        if ((i & jj) == jj) x = x ^ uu[i];
      exp_q.push_back(x);
    end
  endfunction

  task automatic model_clear();
    exp_q.delete();
    info_q.delete();
    phase    = M_LOAD;
    enc_wait = 0;
    pos      = 0;
    acc_cnt  = 0;
    u_model  = '0;
    stalled  = 1'b0;
  endtask

  task automatic queue_info(input logic [K-1:0] info);
    for (int b = 0; b < K; b++) info_q.push_back(info[b]);
  endtask

  // driver + monitor: one cycle, sampled and driven on the falling edge
  task automatic step();
    @(negedge clk);
    check_eq("in_ready", 32'(in_ready), 32'(phase == M_LOAD));
    check_eq("out_valid", 32'(out_valid), 32'(phase == M_OUT));
    if (out_valid && exp_q.size() > 0) begin
      check_eq("out_bit", 32'(out_bit), 32'(exp_q[0]));
      check_eq("out_sym", 32'(out_sym), 32'(exp_q[0] ? SYM_M : SYM_P));
      check_eq("out_last", 32'(out_last), 32'(pos == N - 1));
      if (stalled) begin
        check_eq("hold_bit", 32'(out_bit), 32'(held_bit));
        check_eq("hold_sym", 32'(out_sym), 32'(held_sym));
        check_eq("hold_last", 32'(out_last), 32'(held_last));
      end
    end else if (!out_valid) begin
      check_eq("idle_bit", 32'(out_bit), 0);
      check_eq("idle_sym", 32'(out_sym), 0);
      check_eq("idle_last", 32'(out_last), 0);
    end

    if (use_pattern) begin
      out_ready = rdy_pat[pat_idx % 4];
      if (phase == M_OUT) pat_idx++;
    end else begin
      out_ready = ($urandom_range(99) < rdy_pct);
    end

    if (phase == M_LOAD) begin
      if (info_q.size() > 0 && $urandom_range(99) < in_pct) begin
        in_valid = 1'b1;
        in_bit   = info_q[0];
      end else begin
        in_valid = 1'b0;
        in_bit   = 1'($urandom_range(1));
      end
    end else begin
      in_valid = 1'($urandom_range(1));
      in_bit   = 1'($urandom_range(1));
    end

    stalled = 1'b0;
    case (phase)
      M_LOAD: if (in_valid) begin
        void'(info_q.pop_front());
        u_model[info_idx[acc_cnt]] = in_bit;
        acc_cnt++;
        if (acc_cnt == K) begin
          push_codeword(u_model);
          u_model  = '0;
          acc_cnt  = 0;
          phase    = M_ENC;
          enc_wait = LOG2N;
        end
      end
      M_ENC: begin
        enc_wait--;
        if (enc_wait == 0) phase = M_OUT;
      end
      default: begin
        held_bit  = out_bit;
        held_sym  = out_sym;
        held_last = out_last;
        if (!out_ready) begin
          stalled = 1'b1;
        end else begin
          rx_word[pos] = out_bit;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (pos == N - 1) begin
            done_q.push_back(rx_word);
            pos   = 0;
            phase = M_LOAD;
          end else begin
            pos++;
          end
        end
      end
    endcase
  endtask

  task automatic run_until_idle(input int budget);
    int  c;
    bit  idle;
    c = 0;
    idle = 1'b0;
    while (!idle && c < budget) begin
      step();
      c++;
      idle = (phase == M_LOAD) && (info_q.size() == 0) && (exp_q.size() == 0);
    end
    check_eq("idle_reached", 32'(idle), 1);
  endtask

  task automatic check_word(input string tag, input logic [N-1:0] exp);
    if (done_q.size() > 0) check_eq(tag, 32'(done_q.pop_front()), 32'(exp));
    else check_eq({tag, "_missing"}, 32'(done_q.size()), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 1);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 0);
    check_eq({tag, "_out_bit"}, 32'(out_bit), 0);
    check_eq({tag, "_out_sym"}, 32'(out_sym), 0);
    check_eq({tag, "_out_last"}, 32'(out_last), 0);
  endtask

  initial begin
    int c;
    c = 0;
    for (int i = 0; i < N; i++)
      if (!FROZEN[i]) begin
        info_idx[c] = i;
        c++;
      end
    rdy_pat     = 4'b1001;
    pat_idx     = 0;
    use_pattern = 1'b0;
    in_pct      = 100;
    rdy_pct     = 100;
    rx_word     = '0;
    held_bit    = 1'b0;
    held_sym    = '0;
    held_last   = 1'b0;
    model_clear();

    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // reset in the middle of OUTPUT
    queue_info(4'b1111);
    c = 0;
    while (!(phase == M_OUT && pos >= 2) && c < 100) begin
      step();
      c++;
    end
    check_eq("reach_output", 32'(phase == M_OUT), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    done_q.delete();

    // fresh codeword after reset, info 0,0,0,1
    queue_info(4'b1000);
    run_until_idle(200);
    check_word("word_after_rst", 8'hFF);

    // single info bit 1,0,0,0
    queue_info(4'b0001);
    run_until_idle(200);
    check_word("word_single", 8'h0F);

    // all ones
    queue_info(4'b1111);
    run_until_idle(200);
    check_word("word_all_ones", 8'h96);

    // backpressure pattern 1,0,0,1 with junk in_valid during OUTPUT
    use_pattern = 1'b1;
    pat_idx     = 0;
    queue_info(4'b1111);
    run_until_idle(300);
    check_word("word_backpressure", 8'h96);
    use_pattern = 1'b0;

    // back-to-back codewords
    queue_info(4'b0001);
    queue_info(4'b1000);
    run_until_idle(300);
    check_word("b2b_first", 8'h0F);
    check_word("b2b_second", 8'hFF);

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      in_pct  = int'($urandom_range(100, 30));
      rdy_pct = int'($urandom_range(100, 30));
      queue_info(K'($urandom));
      run_until_idle(500);
    end
    done_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/polar_encoder.md
# polar_encoder

Serial systematic-free polar encoder that builds codewords for the BP decoder datapath. It accepts K information bits one per handshake, inserts frozen zeros per a compile-time mask, and computes x = u·F^{⊗n} with F = [[1,0],[1,1]] in place over log2(N) cycles. It then streams the N code bits plus their BPSK symbols in the decoder's 20-bit sign-magnitude fixed-point format: 1 sign, 7 integer, 12 fraction. It feeds decoder benches and the channel model on the decoder input side.

## Interface
- N, 8: code length; power of two, 2..1024.
- LOG2N, 3: log2(N).
- K, 4: information bits per codeword; must equal the number of zeros in FROZEN.
- FROZEN, 8'h17: bit i = 1 → u_i frozen (forced 0); bit i = 0 → u_i carries information.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  info bit offered.
- in_ready  out  1  encoder accepts an info bit (state LOAD).
- in_bit  in  1  info bit.
- out_valid  out  1  code bit/symbol valid.
- out_ready  in  1  downstream accepts.
- out_bit  out  1  code bit x_j.
- out_sym  out  20  BPSK symbol of x_j: 0 → 20'h01000 (+1.0), 1 → 20'h81000 (−1.0).
- out_last  out  1  high with out_valid on j = N−1.

## Operation
- N-bit register u, info counter (clog2(K+1) bits), position pointer p, stage counter s, output index j (clog2(N) bits).
- States: LOAD, ENCODE, OUTPUT.
- LOAD: in_ready = 1. On in_valid && in_ready, in_bit is written to the next non-frozen index in ascending order: the first accepted bit goes to the lowest index with FROZEN[i] = 0. Frozen positions hold 0. After the K-th accept → ENCODE, s = 0.
- ENCODE: one stage per cycle. For every i with bit s of i = 0: u[i] ← u[i] ^ u[i + 2^s]. After stage LOG2N−1 → OUTPUT, j = 0.
- Result: x_j = XOR of u_i over all i whose bit set contains j's bit set.
- OUTPUT: out_valid = 1, out_bit = u[j], out_sym per mapping, out_last = (j == N−1).
  - On out_valid && out_ready: j increments.
  - Handshake at j = N−1 → LOAD, with u cleared to 0.
- When out_valid = 0: out_bit = 0, out_sym = 20'h00000, out_last = 0.
- in_valid outside LOAD is ignored; no bit is captured.
- No overlap between codewords: in_ready stays 0 from the K-th accept until the cycle after the last output handshake.

## Timing
- Reset (async assert, released sync to clk): state = LOAD, u = 0, all counters 0. in_ready = 1, out_valid = 0, out_bit = 0, out_sym = 0, out_last = 0.
- Reset mid-operation, in any state: the codeword is discarded and all of the above apply immediately.
- K-th info accept at edge t: ENCODE for edges t+1 .. t+LOG2N. out_valid goes high after edge t+LOG2N, so the first symbol is visible LOG2N cycles after the last accept.
- With out_ready held high: N consecutive output cycles. in_ready returns to 1 in the cycle after the out_last handshake.
- Backpressure: while out_valid && !out_ready, out_bit, out_sym, out_last and j hold stable.
- Minimum codeword period with no stalls: K + LOG2N + N cycles.
- All outputs are functions of registered state only; no combinational path from in_valid or out_ready to any output.

## Test plan
- Reset: assert rst mid-OUTPUT → same cycle out_valid = 0, in_ready = 1. After release, a fresh codeword with info 0,0,0,1 yields x = 1,1,1,1,1,1,1,1 and out_sym = 20'h81000 on all 8 outputs.
- Single info bit: info 1,0,0,0 (u3 = 1) → x = 1,1,1,1,0,0,0,0; out_last only on the 8th output.
- All ones: info 1,1,1,1 → x = 0,1,1,0,1,0,0,1. Symbols alternate between 20'h01000 and 20'h81000 accordingly.
- Latency: in_valid held high → the 4th accept at edge t gives out_valid after edge t+3. in_ready is 0 from edge t until the edge after the out_last handshake.
- Backpressure: info 1,1,1,1 with out_ready toggling 1,0,0,1,… → same 8-bit sequence, outputs stable during stalls, no bit dropped or duplicated. in_valid pulsed during OUTPUT is ignored.
- Back-to-back: two codewords (info 1,0,0,0 then 0,0,0,1) with no gaps → outputs 11110000 then 11111111. The second codeword's u has no residue from the first.
